msrv32_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC mux. Holds the architectural

---
 rtl/msrv32_pkg.sv | 25 ++
 rtl/msrv32_ifetch_fifo.sv | 73 +++++++
 rtl/msrv32_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_msrv32_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// msrv32_pkg
//   Definitions shared by the instruction-fetch slice:
//   - AHB-Lite HTRANS encodings used by the fetch master (IDLE, NONSEQ)
//   - fetch FSM state type
//   - fetch fault cause codes, plus a small alignment helper
package msrv32_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  localparam logic CAUSE_BUS_ERROR  = 1'b0;
  localparam logic CAUSE_MISALIGNED = 1'b1;

  // Takes only the two low address bits; instruction fetches are word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/msrv32_ifetch_fifo.sv
// msrv32_ifetch_fifo
//   Synchronous FIFO that buffers fetched {pc, instruction} records between the
//   AHB data phase and decode. Synchronous flush empties it in one cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         discard every entry (has priority over push and pop)
//   push          write push_data (caller guarantees space; push with pop when full is legal)
//   push_data     WIDTH-bit record
//   pop           remove head entry; ignored when empty
//   head_data     head entry
//   valid         FIFO holds at least one entry
//   count         number of entries held (0..DEPTH)
module msrv32_ifetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign valid     = (count_q != '0);
  assign count     = count_q;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // When full, push and pop target the same slot; the head is read before the write lands.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/msrv32_fetch_unit.sv
// msrv32_fetch_unit
//   Instruction-fetch stage behind the PC mux. Holds the fetch PC, issues
//   pipelined AHB-Lite reads (one outstanding data phase), buffers returned
//   words with their PC and presents them to decode on valid/ready.
//   A redirect reloads the PC, flushes the buffer and discards in-flight data.
// Ports:
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   pc_mux_in             next PC from the PC mux
//   redirect_in           pc_mux_in is non-sequential (branch/trap/mret)
//   pc_out                current fetch PC (back to the PC mux)
//   iaddr_out, htrans_out AHB address phase (NONSEQ when requesting, else IDLE)
//   hready_in, hrdata_in, hresp_in   AHB slave response
//   instr_valid_out, instr_out, instr_pc_out, instr_ready_in   decode handshake
//   fetch_fault_out, fault_cause_out, fault_pc_out             sticky fault report
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] pc_mux_in,
  input  logic        redirect_in,
  output logic [31:0] pc_out,
  output logic [31:0] iaddr_out,
  output logic [1:0]  htrans_out,
  input  logic        hready_in,
  input  logic [31:0] hrdata_in,
  input  logic        hresp_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  input  logic        instr_ready_in,
  output logic        fetch_fault_out,
  output logic        fault_cause_out,
  output logic [31:0] fault_pc_out
);

  import msrv32_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic             in_flight_q;
  logic             drop_q;
  logic [31:0]      dp_pc_q;
  logic             fault_q;
  logic             cause_q;
  logic [31:0]      fault_pc_q;

  logic             fifo_valid;
  logic [63:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;

  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   capacity;
  logic             req;
  logic             accept;
  logic             data_done;
  logic             live_done;
  logic             bus_err;
  logic             push;
  logic             pc_misaligned;

  assign pop = fifo_valid && instr_ready_in && !redirect_in;

  // A same-cycle pop frees a slot, which keeps one fetch per cycle with a
  // 2-entry buffer while never letting entries + in-flight exceed FIFO_DEPTH.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight_q};
  assign capacity  = DEPTH_V + {{CNT_W{1'b0}}, pop};

  assign req       = (state_q == FETCH_RUN) && (occupancy < capacity);
  assign accept    = req && hready_in;
  assign data_done = in_flight_q && hready_in;
  assign live_done = data_done && !drop_q && !redirect_in;
  assign bus_err   = live_done && hresp_in && (state_q == FETCH_RUN);
  assign push      = live_done && !hresp_in;

  assign pc_misaligned = is_misaligned(pc_mux_in[1:0]);

  assign pc_out          = pc_q;
  assign htrans_out      = req ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign iaddr_out       = req ? pc_q : '0;
  assign instr_valid_out = fifo_valid;
  assign instr_pc_out    = fifo_head[63:32];
  assign instr_out       = fifo_head[31:0];
  assign fetch_fault_out = fault_q;
  assign fault_cause_out = cause_q;
  assign fault_pc_out    = fault_pc_q;

  msrv32_ifetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .flush    (redirect_in),
    .push     (push),
    .push_data({dp_pc_q, hrdata_in}),
    .pop      (pop),
    .head_data(fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= FETCH_BOOT;
      pc_q        <= BOOT_ADDRESS;
      in_flight_q <= 1'b0;
      drop_q      <= 1'b0;
      dp_pc_q     <= '0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_BUS_ERROR;
      fault_pc_q  <= '0;
    end else begin
      if (accept) begin
        dp_pc_q <= pc_q;
      end
      in_flight_q <= accept || (in_flight_q && !hready_in);

      // A transfer accepted alongside a redirect or a bus error is dead on
      // arrival; a stalled data phase picks up the drop when a redirect hits.
      if (accept) begin
        drop_q <= redirect_in || bus_err;
      end else if (in_flight_q && !hready_in) begin
        drop_q <= drop_q || redirect_in;
      end else begin
        drop_q <= 1'b0;
      end

      if (redirect_in) begin
        pc_q <= pc_mux_in;
        if (pc_misaligned) begin
          state_q    <= FETCH_FAULT;
          fault_q    <= 1'b1;
          cause_q    <= CAUSE_MISALIGNED;
          fault_pc_q <= pc_mux_in;
        end else begin
          state_q <= FETCH_RUN;
          fault_q <= 1'b0;
        end
      end else begin
        if (accept) begin
          pc_q <= pc_mux_in;
        end
        case (state_q)
          FETCH_BOOT: state_q <= FETCH_RUN;
          FETCH_RUN: begin
            if (bus_err) begin
              state_q    <= FETCH_FAULT;
              fault_q    <= 1'b1;
              cause_q    <= CAUSE_BUS_ERROR;
              fault_pc_q <= dp_pc_q;
            end else if (accept && pc_misaligned) begin
              state_q    <= FETCH_FAULT;
              fault_q    <= 1'b1;
              cause_q    <= CAUSE_MISALIGNED;
              fault_pc_q <= pc_mux_in;
            end
          end
          FETCH_FAULT: state_q <= FETCH_FAULT;
          default:     state_q <= FETCH_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// tb_msrv32_fetch_unit
//   Drives the fetch unit with an AHB-Lite memory model (data = f(address)),
//   a PC mux model (pc+4 or redirect target) and a decode consumer. Every
//   live fetch is queued as {pc, word}; decode handshakes pop and compare.
module tb_msrv32_fetch_unit;
  import msrv32_pkg::*;

  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam int unsigned DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] pc_mux_in;
  logic        redirect_in;
  logic [31:0] pc_out;
  logic [31:0] iaddr_out;
  logic [1:0]  htrans_out;
  logic        hready_in;
  logic [31:0] hrdata_in;
  logic        hresp_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_ready_in;
  logic        fetch_fault_out;
  logic        fault_cause_out;
  logic [31:0] fault_pc_out;

  always #5 clk_in = ~clk_in;

  msrv32_fetch_unit #(
    .BOOT_ADDRESS(BOOT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .pc_mux_in      (pc_mux_in),
    .redirect_in    (redirect_in),
    .pc_out         (pc_out),
    .iaddr_out      (iaddr_out),
    .htrans_out     (htrans_out),
    .hready_in      (hready_in),
    .hrdata_in      (hrdata_in),
    .hresp_in       (hresp_in),
    .instr_valid_out(instr_valid_out),
    .instr_out      (instr_out),
    .instr_pc_out   (instr_pc_out),
    .instr_ready_in (instr_ready_in),
    .fetch_fault_out(fetch_fault_out),
    .fault_cause_out(fault_cause_out),
    .fault_pc_out   (fault_pc_out)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    bit          redir;
    logic [31:0] tgt;
    bit          arm_err;
    logic [31:0] err_at;
    int unsigned cycles;
    bit          rdy;
    bit          hrdy;
    bit          chk_htrans;
    logic [1:0]  exp_htrans;
    bit          chk_pc;
    logic [31:0] exp_pc;
    bit          exp_valid;
    bit          exp_fault;
    bit          exp_cause;
    logic [31:0] exp_fault_pc;
  } step_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        sb[$];
  logic        dp_pending = 1'b0;
  logic [31:0] dp_addr = '0;
  logic [31:0] exp_fetch = BOOT;
  bit          err_armed = 1'b0;
  logic [31:0] err_addr = '0;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr = '0;
  int unsigned pops = 0;
  logic        last_valid;
  logic [1:0]  last_htrans;
  logic [31:0] last_iaddr;
  step_t       steps[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, account for the coming posedge.
  task automatic cycle(input bit rdy, input bit hrdy, input bit redir, input logic [31:0] tgt);
    bit   err_now;
    bit   done;
    bit   acc;
    bit   pop;
    exp_t e;
    @(negedge clk_in);
    instr_ready_in = rdy;
    hready_in      = hrdy;
    redirect_in    = redir;
    pc_mux_in      = redir ? tgt : pc_out + 32'd4;
    err_now        = dp_pending && hrdy && !redir && err_armed && (dp_addr == err_addr);
    hresp_in       = err_now;
    hrdata_in      = dp_pending ? mem_word(dp_addr) : '0;
    #1;
    last_valid  = instr_valid_out;
    last_htrans = htrans_out;
    last_iaddr  = iaddr_out;
    done = dp_pending && hrdy;
    acc  = (htrans_out == HTRANS_NONSEQ) && hrdy;
    pop  = instr_valid_out && rdy && !redir;

    if (hold_pending) begin
      check("hold_htrans", {30'b0, htrans_out}, {30'b0, HTRANS_NONSEQ});
      check("hold_iaddr", iaddr_out, hold_addr);
    end
    hold_pending = (htrans_out == HTRANS_NONSEQ) && !hrdy && !redir;
    hold_addr    = iaddr_out;

    if (pop) begin
      pops++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got output pc 0x%0h, expected none", instr_pc_out);
      end else begin
        e = sb.pop_front();
        check("instr_pc", instr_pc_out, e.pc);
        check("instr", instr_out, e.instr);
      end
    end
    if (err_now) begin
      err_armed = 1'b0;
      if (sb.size() > 0) void'(sb.pop_back());
    end
    if (acc) begin
      check("iaddr", iaddr_out, exp_fetch);
      if (!redir && !err_now) sb.push_back({exp_fetch, mem_word(exp_fetch)});
      dp_addr    = exp_fetch;
      dp_pending = 1'b1;
      exp_fetch  = exp_fetch + 32'd4;
    end else if (done) begin
      dp_pending = 1'b0;
    end
    if (redir) begin
      sb.delete();
      exp_fetch = tgt;
    end
  endtask

  initial begin
    // redir tgt arm err_at cyc rdy hrdy chk_ht exp_ht chk_pc exp_pc valid fault cause fault_pc
    steps[0]  = '{1, 32'h200, 0, 32'h0, 6,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};
    steps[1]  = '{0, 32'h0,   0, 32'h0, 10, 0, 1, 1, HTRANS_IDLE,   0, 32'h0,   1, 0, 0, 32'h0};
    steps[2]  = '{0, 32'h0,   0, 32'h0, 6,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};
    steps[3]  = '{0, 32'h0,   0, 32'h0, 3,  1, 0, 1, HTRANS_NONSEQ, 0, 32'h0,   0, 0, 0, 32'h0};
    steps[4]  = '{0, 32'h0,   0, 32'h0, 4,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};
    steps[5]  = '{0, 32'h0,   0, 32'h0, 2,  0, 0, 1, HTRANS_IDLE,   0, 32'h0,   1, 0, 0, 32'h0};
    steps[6]  = '{1, 32'h100, 0, 32'h0, 1,  1, 0, 1, HTRANS_NONSEQ, 1, 32'h100, 0, 0, 0, 32'h0};
    steps[7]  = '{0, 32'h0,   0, 32'h0, 6,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};
    steps[8]  = '{1, 32'h0,   1, 32'h8, 8,  1, 1, 1, HTRANS_IDLE,   0, 32'h0,   0, 1, 0, 32'h8};
    steps[9]  = '{1, 32'h40,  0, 32'h0, 6,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};
    steps[10] = '{1, 32'h102, 0, 32'h0, 4,  1, 1, 1, HTRANS_IDLE,   1, 32'h102, 0, 1, 1, 32'h102};
    steps[11] = '{1, 32'h80,  0, 32'h0, 5,  1, 1, 1, HTRANS_NONSEQ, 0, 32'h0,   1, 0, 0, 32'h0};

    rst_n_in       = 1'b0;
    pc_mux_in      = '0;
    redirect_in    = 1'b0;
    hready_in      = 1'b1;
    hrdata_in      = '0;
    hresp_in       = 1'b0;
    instr_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_pc", pc_out, BOOT);
    check("rst_htrans", {30'b0, htrans_out}, {30'b0, HTRANS_IDLE});
    check("rst_iaddr", iaddr_out, 32'h0);
    check("rst_valid", {31'b0, instr_valid_out}, 32'h0);
    check("rst_fault", {31'b0, fetch_fault_out}, 32'h0);
    check("rst_cause", {31'b0, fault_cause_out}, 32'h0);
    check("rst_fault_pc", fault_pc_out, 32'h0);

    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("boot_idle", {30'b0, htrans_out}, {30'b0, HTRANS_IDLE});

    cycle(1'b1, 1'b1, 1'b0, '0);
    check("first_htrans", {30'b0, last_htrans}, {30'b0, HTRANS_NONSEQ});
    check("first_iaddr", last_iaddr, BOOT);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("first_dphase_valid", {31'b0, last_valid}, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("first_valid", {31'b0, last_valid}, 32'h1);
    pops = 0;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
    check("throughput", pops, 32'd12);

    for (int unsigned i = 0; i < 12; i++) begin
      err_armed = steps[i].arm_err;
      err_addr  = steps[i].err_at;
      for (int unsigned c = 0; c < steps[i].cycles; c++) begin
        cycle(steps[i].rdy, steps[i].hrdy, steps[i].redir && (c == 0), steps[i].tgt);
      end
      @(posedge clk_in);
      #1;
      check($sformatf("s%0d_valid", i), {31'b0, instr_valid_out}, {31'b0, steps[i].exp_valid});
      check($sformatf("s%0d_fault", i), {31'b0, fetch_fault_out}, {31'b0, steps[i].exp_fault});
      if (steps[i].chk_htrans)
        check($sformatf("s%0d_htrans", i), {30'b0, htrans_out}, {30'b0, steps[i].exp_htrans});
      if (steps[i].chk_pc)
        check($sformatf("s%0d_pc", i), pc_out, steps[i].exp_pc);
      if (steps[i].exp_fault) begin
        check($sformatf("s%0d_cause", i), {31'b0, fault_cause_out}, {31'b0, steps[i].exp_cause});
        check($sformatf("s%0d_fault_pc", i), fault_pc_out, steps[i].exp_fault_pc);
      end
    end

    // Asynchronous reset in the middle of streaming traffic.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid_out}, 32'h0);
    check("mid_rst_pc", pc_out, BOOT);
    check("mid_rst_htrans", {30'b0, htrans_out}, {30'b0, HTRANS_IDLE});
    check("mid_rst_fault", {31'b0, fetch_fault_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
